// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - scancodes, joystick indices, key latch types and coin FSM states
// Shared definitions for the arcade input conditioning stage.
package arcade_input_pkg;

   // Player 1 directions ignore the extended bit, so only [7:0] of these is compared
   localparam logic [8:0] SC_UP       = 9'h075;
   localparam logic [8:0] SC_DOWN     = 9'h072;
   localparam logic [8:0] SC_LEFT     = 9'h06B;
   localparam logic [8:0] SC_RIGHT    = 9'h074;
   localparam logic [8:0] SC_FIRE     = 9'h014;
   localparam logic [8:0] SC_BOMB     = 9'h029;
   localparam logic [8:0] SC_P2_UP    = 9'h02D;
   localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
   localparam logic [8:0] SC_P2_LEFT  = 9'h023;
   localparam logic [8:0] SC_P2_RIGHT = 9'h034;
   localparam logic [8:0] SC_P2_FIRE  = 9'h01C;
   localparam logic [8:0] SC_P2_BOMB  = 9'h01B;
   localparam logic [8:0] SC_F1       = 9'h005;
   localparam logic [8:0] SC_1        = 9'h016;
   localparam logic [8:0] SC_F2       = 9'h006;
   localparam logic [8:0] SC_2        = 9'h01E;
   localparam logic [8:0] SC_5        = 9'h02E;
   localparam logic [8:0] SC_6        = 9'h036;
   localparam logic [8:0] SC_TEST     = 9'h02C;

   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_BOMB   = 5;
   localparam int JOY_START  = 6;
   localparam int JOY_START2 = 7;
   localparam int JOY_COIN   = 8;

   typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} coin_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fire;
      logic bomb;
   } player_t;

   typedef struct packed {
      player_t p1;
      player_t p2;
      logic    f1;
      logic    one;
      logic    f2;
      logic    two;
      logic    c5;
      logic    c6;
      logic    test;
   } keys_t;

   function automatic player_t joy_player(input logic [15:0] j);
      return {j[JOY_UP], j[JOY_DOWN], j[JOY_LEFT], j[JOY_RIGHT], j[JOY_FIRE], j[JOY_BOMB]};
   endfunction

   function automatic player_t socd_clean(input player_t p, input logic en);
      player_t r;
      r = p;
      if (en && p.up && p.down) begin
         r.up   = 1'b0;
         r.down = 1'b0;
      end
      if (en && p.left && p.right) begin
         r.left  = 1'b0;
         r.right = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/arcade_input_cond_if.sv
// rtl/arcade_input_cond_if.sv - input sources and active-low button buses of the conditioning stage
// master is the platform/bench side, slave is the conditioning block.
interface arcade_input_cond_if;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic        socd_en;
   logic [1:0]  but_coin_s;
   logic [1:0]  but_fire_s;
   logic [1:0]  but_bomb_s;
   logic [1:0]  but_tilt_s;
   logic [1:0]  but_select_s;
   logic [1:0]  but_up_s;
   logic [1:0]  but_down_s;
   logic [1:0]  but_left_s;
   logic [1:0]  but_right_s;

   modport master (
      output ps2_key, joystick_0, joystick_1, socd_en,
      input  but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s,
             but_up_s, but_down_s, but_left_s, but_right_s
   );

   modport slave (
      input  ps2_key, joystick_0, joystick_1, socd_en,
      output but_coin_s, but_fire_s, but_bomb_s, but_tilt_s, but_select_s,
             but_up_s, but_down_s, but_left_s, but_right_s
   );
endinterface

// File: rtl/arcade_input_cond_coin_pulser.sv
// rtl/arcade_input_cond_coin_pulser.sv - coin request edge detect with fixed-width pulse and holdoff
// pulse_n is registered and goes low on the edge that accepts a coin.
module coin_pulser
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC   = 4,
   parameter int COIN_HOLDOFF_CYC = 8,
   parameter int CNT_W            = 20
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic req,
   output logic pulse_n
);
   coin_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             req_d;
   logic             rise;

   assign rise = req & ~req_d;

   // Edges seen outside IDLE are simply lost, so a held or bouncing coin gives one pulse
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         req_d   <= 1'b0;
         pulse_n <= 1'b1;
      end else begin
         req_d <= req;
         case (state)
            IDLE: begin
               if (rise) begin
                  state   <= PULSE;
                  cnt     <= CNT_W'(COIN_PULSE_CYC - 1);
                  pulse_n <= 1'b0;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  state   <= HOLDOFF;
                  cnt     <= CNT_W'(COIN_HOLDOFF_CYC - 1);
                  pulse_n <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HOLDOFF: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            default: begin
               state   <= IDLE;
               pulse_n <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: rtl/arcade_input_cond.sv
// rtl/arcade_input_cond.sv - keyboard decode, joystick merge, SOCD cleaning and coin shaping
// All button outputs are active-low and registered.
module arcade_input_cond
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC   = 4,
   parameter int COIN_HOLDOFF_CYC = 8,
   parameter int CNT_W            = 20
) (
   input  logic clk_sys,
   input  logic reset_n,
   arcade_input_cond_if.slave bus
);
   logic       tog_d;
   logic       primed;
   logic       key_event;
   logic       pressed;
   logic [8:0] code;
   keys_t      keys;

   assign pressed   = bus.ps2_key[9];
   assign code      = bus.ps2_key[8:0];
   assign key_event = primed & (bus.ps2_key[10] ^ tog_d);

   // The first edge after reset only captures the toggle level, so a stale toggle is not an event
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_d  <= 1'b0;
         primed <= 1'b0;
         keys   <= '0;
      end else begin
         tog_d  <= bus.ps2_key[10];
         primed <= 1'b1;
         if (key_event) begin
            case (code[7:0])
               SC_UP[7:0]:    keys.p1.up    <= pressed;
               SC_DOWN[7:0]:  keys.p1.down  <= pressed;
               SC_LEFT[7:0]:  keys.p1.left  <= pressed;
               SC_RIGHT[7:0]: keys.p1.right <= pressed;
               default: ;
            endcase
            case (code)
               SC_FIRE:     keys.p1.fire  <= pressed;
               SC_BOMB:     keys.p1.bomb  <= pressed;
               SC_P2_UP:    keys.p2.up    <= pressed;
               SC_P2_DOWN:  keys.p2.down  <= pressed;
               SC_P2_LEFT:  keys.p2.left  <= pressed;
               SC_P2_RIGHT: keys.p2.right <= pressed;
               SC_P2_FIRE:  keys.p2.fire  <= pressed;
               SC_P2_BOMB:  keys.p2.bomb  <= pressed;
               SC_F1:       keys.f1       <= pressed;
               SC_1:        keys.one      <= pressed;
               SC_F2:       keys.f2       <= pressed;
               SC_2:        keys.two      <= pressed;
               SC_5:        keys.c5       <= pressed;
               SC_6:        keys.c6       <= pressed;
               SC_TEST:     keys.test     <= pressed;
               default: ;
            endcase
         end
      end
   end

   player_t p1;
   player_t p2;
   player_t p1_c;
   player_t p2_c;
   logic    start1;
   logic    start2;
   logic    coin_req;

   always_comb begin
      p1       = player_t'(keys.p1 | joy_player(bus.joystick_0));
      p2       = player_t'(keys.p2 | joy_player(bus.joystick_1));
      p1_c     = socd_clean(p1, bus.socd_en);
      p2_c     = socd_clean(p2, bus.socd_en);
      start1   = keys.f1 | keys.one | bus.joystick_0[JOY_START];
      start2   = keys.f2 | keys.two | bus.joystick_0[JOY_START2] | bus.joystick_1[JOY_START];
      coin_req = keys.c5 | keys.c6 | bus.joystick_0[JOY_COIN] | bus.joystick_1[JOY_COIN];
   end

   logic [1:0] fire_q, bomb_q, select_q, up_q, down_q, left_q, right_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         fire_q   <= 2'b11;
         bomb_q   <= 2'b11;
         select_q <= 2'b11;
         up_q     <= 2'b11;
         down_q   <= 2'b11;
         left_q   <= 2'b11;
         right_q  <= 2'b11;
      end else begin
         fire_q   <= ~{p2_c.fire,  p1_c.fire};
         bomb_q   <= ~{p2_c.bomb,  p1_c.bomb};
         select_q <= ~{start2,     start1};
         up_q     <= ~{p2_c.up,    p1_c.up};
         down_q   <= ~{p2_c.down,  p1_c.down};
         left_q   <= ~{p2_c.left,  p1_c.left};
         right_q  <= ~{p2_c.right, p1_c.right};
      end
   end

   logic coin_n;

   coin_pulser #(
      .COIN_PULSE_CYC  (COIN_PULSE_CYC),
      .COIN_HOLDOFF_CYC(COIN_HOLDOFF_CYC),
      .CNT_W           (CNT_W)
   ) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .req    (coin_req),
      .pulse_n(coin_n)
   );

   assign bus.but_coin_s   = {1'b1, coin_n};
   assign bus.but_tilt_s   = 2'b11;
   assign bus.but_fire_s   = fire_q;
   assign bus.but_bomb_s   = bomb_q;
   assign bus.but_select_s = select_q;
   assign bus.but_up_s     = up_q;
   assign bus.but_down_s   = down_q;
   assign bus.but_left_s   = left_q;
   assign bus.but_right_s  = right_q;

   logic unused_bits;
   assign unused_bits = &{1'b0, bus.joystick_0[15:9], bus.joystick_1[15:9],
                          bus.joystick_1[JOY_START2], keys.test};
endmodule

// File: tb/tb_arcade_input_cond.sv
// tb/tb_arcade_input_cond.sv - directed self-checking bench for arcade_input_cond
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_arcade_input_cond;
   import arcade_input_pkg::*;

   logic clk_sys = 1'b0;
   logic reset_n;
   logic tog;
   int   passed = 0;
   int   total  = 0;

   always #5 clk_sys = ~clk_sys;

   arcade_input_cond_if bus_if ();

   arcade_input_cond #(
      .COIN_PULSE_CYC  (4),
      .COIN_HOLDOFF_CYC(8),
      .CNT_W           (20)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .bus    (bus_if.slave)
   );

   function automatic logic [17:0] all_outs();
      return {bus_if.but_coin_s, bus_if.but_fire_s, bus_if.but_bomb_s, bus_if.but_tilt_s,
              bus_if.but_select_s, bus_if.but_up_s, bus_if.but_down_s, bus_if.but_left_s,
              bus_if.but_right_s};
   endfunction

   task automatic send_key(input logic pressed, input logic [8:0] code);
      @(negedge clk_sys);
      tog = ~tog;
      bus_if.ps2_key = {tog, pressed, code};
      @(posedge clk_sys);
   endtask

   // Drives single-cycle coin requests on the listed cycle indices and measures the output
   task automatic run_coin(input int e0, input int e1, input int e2, output int lows, output int pulses);
      logic prev;
      lows   = 0;
      pulses = 0;
      prev   = 1'b1;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk_sys);
         if (!bus_if.but_coin_s[0]) lows++;
         if (prev && !bus_if.but_coin_s[0]) pulses++;
         prev = bus_if.but_coin_s[0];
         bus_if.joystick_0[JOY_COIN] = (i == e0) || (i == e1) || (i == e2);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         bus_if.ps2_key    = 11'($urandom);
         bus_if.joystick_0 = 16'($urandom);
         bus_if.joystick_1 = 16'($urandom);
         bus_if.socd_en    = 1'($urandom);
         #1;
         total++;
         if (all_outs() !== '1) $display("FAIL reset_outs got=%h exp=%h", all_outs(), 18'h3ffff);
         else passed++;
      end
      @(negedge clk_sys);
      bus_if.joystick_0 = '0;
      bus_if.joystick_1 = '0;
      bus_if.socd_en    = 1'b1;
      tog = 1'b1;
      bus_if.ps2_key = {tog, 1'b1, SC_UP};
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);
      total++;
      if (bus_if.but_up_s !== 2'b11) $display("FAIL priming up got=%b exp=%b", bus_if.but_up_s, 2'b11);
      else passed++;
      total++;
      if (all_outs() !== '1) $display("FAIL post_reset_outs got=%h exp=%h", all_outs(), 18'h3ffff);
      else passed++;
   endtask

   task automatic test_key_up;
      logic [8:0] codes [2];
      codes[0] = 9'h075;
      codes[1] = 9'h175;
      for (int c = 0; c < 2; c++) begin
         send_key(1'b1, codes[c]);
         @(negedge clk_sys);
         total++;
         if (bus_if.but_up_s !== 2'b11) $display("FAIL up_latency code=%h got=%b exp=%b", codes[c], bus_if.but_up_s, 2'b11);
         else passed++;
         @(negedge clk_sys);
         total++;
         if (bus_if.but_up_s !== 2'b10) $display("FAIL up_press code=%h got=%b exp=%b", codes[c], bus_if.but_up_s, 2'b10);
         else passed++;
         send_key(1'b0, codes[c]);
         repeat (2) @(negedge clk_sys);
         total++;
         if (bus_if.but_up_s !== 2'b11) $display("FAIL up_release code=%h got=%b exp=%b", codes[c], bus_if.but_up_s, 2'b11);
         else passed++;
      end
   endtask

   task automatic test_keys_misc;
      send_key(1'b1, 9'h114);
      repeat (2) @(negedge clk_sys);
      total++;
      if (bus_if.but_fire_s !== 2'b11) $display("FAIL ext_fire_ignored got=%b exp=%b", bus_if.but_fire_s, 2'b11);
      else passed++;
      send_key(1'b1, SC_P2_FIRE);
      bus_if.joystick_0[JOY_BOMB]   = 1'b1;
      bus_if.joystick_0[JOY_START2] = 1'b1;
      repeat (2) @(negedge clk_sys);
      total++;
      if (bus_if.but_fire_s !== 2'b01) $display("FAIL p2_fire got=%b exp=%b", bus_if.but_fire_s, 2'b01);
      else passed++;
      total++;
      if (bus_if.but_bomb_s !== 2'b10) $display("FAIL p1_bomb_joy got=%b exp=%b", bus_if.but_bomb_s, 2'b10);
      else passed++;
      total++;
      if (bus_if.but_select_s !== 2'b01) $display("FAIL start2_joy got=%b exp=%b", bus_if.but_select_s, 2'b01);
      else passed++;
      send_key(1'b1, SC_F1);
      repeat (2) @(negedge clk_sys);
      total++;
      if (bus_if.but_select_s !== 2'b00) $display("FAIL start1_key got=%b exp=%b", bus_if.but_select_s, 2'b00);
      else passed++;
      send_key(1'b0, SC_F1);
      send_key(1'b0, SC_P2_FIRE);
      bus_if.joystick_0 = '0;
      repeat (2) @(negedge clk_sys);
      total++;
      if (all_outs() !== '1) $display("FAIL misc_release got=%h exp=%h", all_outs(), 18'h3ffff);
      else passed++;
   endtask

   task automatic test_socd;
      @(negedge clk_sys);
      bus_if.socd_en    = 1'b1;
      bus_if.joystick_1 = 16'h000C;
      @(negedge clk_sys);
      total++;
      if ({bus_if.but_up_s[1], bus_if.but_down_s[1]} !== 2'b11)
         $display("FAIL socd_p2_ud_on got=%b exp=%b", {bus_if.but_up_s[1], bus_if.but_down_s[1]}, 2'b11);
      else passed++;
      bus_if.socd_en = 1'b0;
      @(negedge clk_sys);
      total++;
      if ({bus_if.but_up_s[1], bus_if.but_down_s[1]} !== 2'b00)
         $display("FAIL socd_p2_ud_off got=%b exp=%b", {bus_if.but_up_s[1], bus_if.but_down_s[1]}, 2'b00);
      else passed++;
      bus_if.joystick_1 = '0;
      bus_if.socd_en    = 1'b1;
      send_key(1'b1, SC_LEFT);
      send_key(1'b1, SC_RIGHT);
      repeat (2) @(negedge clk_sys);
      total++;
      if ({bus_if.but_left_s, bus_if.but_right_s} !== 4'b1111)
         $display("FAIL socd_p1_lr_on got=%b exp=%b", {bus_if.but_left_s, bus_if.but_right_s}, 4'b1111);
      else passed++;
      bus_if.socd_en = 1'b0;
      @(negedge clk_sys);
      total++;
      if ({bus_if.but_left_s, bus_if.but_right_s} !== 4'b1010)
         $display("FAIL socd_p1_lr_off got=%b exp=%b", {bus_if.but_left_s, bus_if.but_right_s}, 4'b1010);
      else passed++;
      send_key(1'b0, SC_LEFT);
      send_key(1'b0, SC_RIGHT);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_coin_hold;
      int  lows;
      int  pulses;
      logic prev;
      lows   = 0;
      pulses = 0;
      prev   = 1'b1;
      @(negedge clk_sys);
      bus_if.joystick_0[JOY_COIN] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         if (!bus_if.but_coin_s[0]) lows++;
         if (prev && !bus_if.but_coin_s[0]) pulses++;
         prev = bus_if.but_coin_s[0];
      end
      bus_if.joystick_0[JOY_COIN] = 1'b0;
      total++;
      if (lows !== 4) $display("FAIL coin_hold_width got=%0d exp=%0d", lows, 4);
      else passed++;
      total++;
      if (pulses !== 1) $display("FAIL coin_hold_count got=%0d exp=%0d", pulses, 1);
      else passed++;
      total++;
      if (bus_if.but_coin_s[1] !== 1'b1) $display("FAIL coin_bit1 got=%b exp=%b", bus_if.but_coin_s[1], 1'b1);
      else passed++;
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic test_coin_retrigger;
      int lows;
      int pulses;
      run_coin(0, 6, 13, lows, pulses);
      total++;
      if (pulses !== 2) $display("FAIL retrig_6_13_count got=%0d exp=%0d", pulses, 2);
      else passed++;
      total++;
      if (lows !== 8) $display("FAIL retrig_6_13_width got=%0d exp=%0d", lows, 8);
      else passed++;
      run_coin(0, 12, -1, lows, pulses);
      total++;
      if (pulses !== 1) $display("FAIL retrig_12_count got=%0d exp=%0d", pulses, 1);
      else passed++;
      total++;
      if (lows !== 4) $display("FAIL retrig_12_width got=%0d exp=%0d", lows, 4);
      else passed++;
   endtask

   task automatic test_reset_mid_pulse;
      int lows;
      int pulses;
      @(negedge clk_sys);
      bus_if.joystick_0[JOY_COIN] = 1'b1;
      @(negedge clk_sys);
      total++;
      if (bus_if.but_coin_s[0] !== 1'b0) $display("FAIL mid_pulse_start got=%b exp=%b", bus_if.but_coin_s[0], 1'b0);
      else passed++;
      @(posedge clk_sys);
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (bus_if.but_coin_s[0] !== 1'b1) $display("FAIL mid_pulse_async_reset got=%b exp=%b", bus_if.but_coin_s[0], 1'b1);
      else passed++;
      bus_if.joystick_0[JOY_COIN] = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      run_coin(0, -1, -1, lows, pulses);
      total++;
      if (lows !== 4 || pulses !== 1) $display("FAIL post_reset_coin got=%0d/%0d exp=4/1", lows, pulses);
      else passed++;
   endtask

   initial begin
      reset_n = 1'b0;
      tog     = 1'b0;
      bus_if.ps2_key    = '0;
      bus_if.joystick_0 = '0;
      bus_if.joystick_1 = '0;
      bus_if.socd_en    = 1'b0;
      test_reset;
      test_key_up;
      test_keys_misc;
      test_socd;
      test_coin_hold;
      test_coin_retrigger;
      test_reset_mid_pulse;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
